// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone B4 classic, single-outstanding load/store initiator with byte-lane
// steering and misalignment checking. Define WBI_TIMEOUT_EN to abort cycles that never get ack/err.
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [29:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [29:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic        timeout;
  logic        bus_done;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign accept   = req_valid_i && (state_q == S_IDLE);
  assign bus_done = (state_q == S_BUS) && (wb_ack_i || wb_err_i || timeout);

  always_comb begin
    unique case (req_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    req_sel = 4'b1111;
    req_dat = req_wdata_i;
    case (req_size_i)
      2'd0: begin
        req_sel = 4'b0001 << req_addr_i[1:0];
        req_dat = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_sel = 4'b0011 << {req_addr_i[1], 1'b0};
        req_dat = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load data is right-justified by the byte offset, then trimmed to the access size.
  assign ld_shift = wb_dat_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    ld_data = {24'h0, ld_shift[7:0]};
      2'd1:    ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

`ifdef WBI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;

  // Expires on the edge that completes the TIMEOUT_CYCLES-th strobe cycle.
  assign timeout = (state_q == S_BUS) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (accept) begin
      tmo_d = '0;
    end else if (state_q == S_BUS) begin
      tmo_d = tmo_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = misaligned ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        if (bus_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    off_d   = off_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      if (misaligned) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cyc_d  = 1'b1;
        adr_d  = req_addr_i[31:2];
        we_d   = req_we_i;
        sel_d  = req_sel;
        dat_d  = req_dat;
        off_d  = req_addr_i[1:0];
        size_d = req_size_i;
      end
    end else if (bus_done) begin
      cyc_d = 1'b0;
      // err beats ack; an expiry without ack is also an error
      if (wb_err_i || !wb_ack_i) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        err_d   = 1'b0;
        rdata_d = we_q ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      off_q   <= off_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE) && !wb_rst_i;
    resp_valid_o = (state_q == S_RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    wb_cyc_o     = cyc_q;
    wb_stb_o     = cyc_q;
    wb_adr_o     = adr_q;
    wb_dat_o     = dat_q;
    wb_we_o      = we_q;
    wb_sel_o     = sel_q;
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Testbench for wb_initiator: directed and random loads/stores against a byte-array memory model
// and a small Wishbone RAM responder with selectable ack/err/silent behaviour.
module tb_wb_initiator;

  localparam int unsigned M_ACK    = 0;
  localparam int unsigned M_ERR    = 1;
  localparam int unsigned M_BOTH   = 2;
  localparam int unsigned M_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cyc, stb, we_o, ack, err;
  logic [29:0] adr;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel;

  logic        ack_r, err_r, stray_ack, stray_err;
  logic [31:0] rd_r;
  logic [31:0] ram [16];
  logic [7:0]  ref_mem [64];
  int unsigned mode;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .wb_cyc_o     (cyc),
    .wb_stb_o     (stb),
    .wb_adr_o     (adr),
    .wb_dat_o     (dat_o),
    .wb_dat_i     (dat_i),
    .wb_we_o      (we_o),
    .wb_sel_o     (sel),
    .wb_ack_i     (ack),
    .wb_err_i     (err)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 1) return 32'h1234_5678;
    if (i == 4) return 32'hDEAD_BEEF;
    return {4{8'(i * 17 + 3)}} ^ 32'h0F1E_2D3C;
  endfunction

  assign ack   = ack_r | stray_ack;
  assign err   = err_r | stray_err;
  assign dat_i = rd_r;

  // Registered responder: one ack/err per strobe, RAM written only on a clean ack.
  always @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      rd_r  <= '0;
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (cyc && stb && !ack_r && !err_r) begin
        case (mode)
          M_ACK: begin
            ack_r <= 1'b1;
            rd_r  <= ram[adr[3:0]];
            if (we_o)
              for (int i = 0; i < 4; i++)
                if (sel[i]) ram[adr[3:0]][8*i +: 8] <= dat_o[8*i +: 8];
          end
          M_ERR: begin
            err_r <= 1'b1;
            rd_r  <= 32'hFFFF_FFFF;
          end
          M_BOTH: begin
            ack_r <= 1'b1;
            err_r <= 1'b1;
            rd_r  <= ram[adr[3:0]];
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = w;
    req_size  = s;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Full transaction with expectations derived from the byte-array model.
  task automatic run_req(input string tag, input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic [31:0] d, input int unsigned m);
    int unsigned nb, off, n;
    logic        mis, exp_err, seen;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat, exp_rdata;
    off = a % 4;
    nb  = 1 << s;
    mis = (s == 2'd3) || ((off % nb) != 0);
    exp_sel = 4'(((1 << nb) - 1) << off);
    exp_dat = '0;
    if (s != 2'd3)
      for (int i = 0; i < 4; i++) exp_dat[8*i +: 8] = d[8*(i % nb) +: 8];
    exp_err   = mis || (m != M_ACK);
    exp_rdata = '0;
    if (!exp_err) begin
      for (int k = 0; k < nb; k++) begin
        if (w) ref_mem[(a + k) % 64] = d[8*k +: 8];
        else   exp_rdata[8*k +: 8] = ref_mem[(a + k) % 64];
      end
    end
    mode = m;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = w;
    req_size  = s;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " cyc"}, 32'(cyc), 32'(!mis));
        if (!mis) begin
          chk({tag, " stb"}, 32'(stb), 32'd1);
          chk({tag, " adr"}, 32'(adr), 32'(a[31:2]));
          chk({tag, " sel"}, 32'(sel), 32'(exp_sel));
          chk({tag, " dat_o"}, dat_o, exp_dat);
          chk({tag, " we"}, 32'(we_o), 32'(w));
        end
      end
      if (resp_valid) seen = 1'b1;
    end
    chk({tag, " latency"}, n, mis ? 32'd1 : 32'd3);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, " rdata"}, resp_rdata, exp_rdata);
    chk({tag, " cyc at resp"}, 32'(cyc), 32'd0);
    @(negedge clk);
    chk({tag, " resp pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic        ok;
    int unsigned n;
    logic [31:0] exp_word;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0; req_wdata = '0;
    stray_ack = 1'b0; stray_err = 1'b0; mode = M_ACK;
    for (int b = 0; b < 64; b++) begin
      w = init_word(b / 4);
      ref_mem[b] = w[8*(b % 4) +: 8];
    end

    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst cyc", 32'(cyc), 32'd0);
    chk("rst stb", 32'(stb), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst dat_o", dat_o, 32'd0);
    chk("rst we", 32'(we_o), 32'd0);
    rst = 1'b0;

    run_req("ld_word_10", 32'h0000_0010, 1'b0, 2'd2, 32'h0, M_ACK);
    chk("ld_word_10 value", resp_rdata, 32'hDEAD_BEEF);
    run_req("st_byte_13", 32'h0000_0013, 1'b1, 2'd0, 32'h0000_00A5, M_ACK);
    run_req("reload_10", 32'h0000_0010, 1'b0, 2'd2, 32'h0, M_ACK);
    chk("reload_10 value", resp_rdata, 32'hA5AD_BEEF);
    run_req("ld_half_06", 32'h0000_0006, 1'b0, 2'd1, 32'h0, M_ACK);
    chk("ld_half_06 value", resp_rdata, 32'h0000_1234);
    run_req("mis_half_05", 32'h0000_0005, 1'b0, 2'd1, 32'h0, M_ACK);
    run_req("mis_size3", 32'h0000_0008, 1'b1, 2'd3, 32'h1111_2222, M_ACK);
    run_req("mis_word_02", 32'h0000_0002, 1'b0, 2'd2, 32'h0, M_ACK);
    run_req("ack_err_both", 32'h0000_0004, 1'b0, 2'd2, 32'h0, M_BOTH);
    run_req("bus_err_st", 32'h0000_0020, 1'b1, 2'd2, 32'hCAFE_F00D, M_ERR);
    run_req("st_half_1a", 32'h0000_001A, 1'b1, 2'd1, 32'h5566_BEAD, M_ACK);
    run_req("ld_byte_1b", 32'h0000_001B, 1'b0, 2'd0, 32'h0, M_ACK);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      int unsigned r, m;
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      m = (r == 0) ? M_ERR : (r == 1) ? M_BOTH : M_ACK;
      run_req($sformatf("rnd%0d", i), 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              s, $urandom, m);
    end

    // Stray ack/err while idle must not produce a response or a cycle.
    @(negedge clk);
    stray_ack = 1'b1;
    stray_err = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    stray_err = 1'b0;
    chk("stray resp_valid", 32'(resp_valid), 32'd0);
    chk("stray cyc", 32'(cyc), 32'd0);
    @(negedge clk);
    chk("stray resp_valid2", 32'(resp_valid), 32'd0);
    chk("stray ready", 32'(req_ready), 32'd1);

    mode = M_SILENT;
    issue(32'h0000_0010, 1'b0, 2'd2, 32'h0);
`ifdef WBI_TIMEOUT_EN
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cyc) n++;
      else ok = 1'b1;
    end
    chk("tmo stb cycles", n, 32'd8);
    chk("tmo resp_valid", 32'(resp_valid), 32'd1);
    chk("tmo err", 32'(resp_err), 32'd1);
    chk("tmo rdata", resp_rdata, 32'd0);
`else
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (!cyc || !stb || resp_valid) ok = 1'b0;
    end
    chk("no_tmo hold 1000", 32'(ok), 32'd1);
    mode = M_ACK;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_word = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
    chk("no_tmo late ack", 32'(resp_valid), 32'd1);
    chk("no_tmo err", 32'(resp_err), 32'd0);
    chk("no_tmo rdata", resp_rdata, exp_word);
`endif
    @(negedge clk);

    // Reset in the middle of a bus cycle abandons it silently.
    mode = M_SILENT;
    issue(32'h0000_0030, 1'b1, 2'd2, 32'h0BAD_0BAD);
    @(negedge clk);
    chk("rstbus cyc before", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstbus cyc", 32'(cyc), 32'd0);
    chk("rstbus resp_valid", 32'(resp_valid), 32'd0);
    chk("rstbus ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || cyc) ok = 1'b0;
    end
    chk("rstbus quiet", 32'(ok), 32'd1);
    chk("rstbus ready after", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
